db_cfg_sequencer: RTL

// - Turns the four debounced button levels (HS, VS, DF_UART, DF_VGA) into configuration updates.
// - Detects each rising edge and queues it as a pending event; events pressed together are

---
 rtl/db_cfg_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/db_cfg_sequencer.sv
// Button-to-configuration sequencer: rising edges of four debounced buttons become
// pending events, served round-robin, each written downstream over a valid/ready port.
module db_cfg_sequencer #(
    parameter int OFF_W      = 10,
    parameter int HS_STEP    = 8,
    parameter int VS_STEP    = 8,
    parameter int H_MAX      = 639,
    parameter int V_MAX      = 479,
    parameter int UART_FMT_N = 4,
    parameter int VGA_FMT_N  = 3,
    parameter int ACK_TMO    = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             HS,
    input  logic             VS,
    input  logic             DF_UART,
    input  logic             DF_VGA,
    input  logic             err_clr,
    output logic             cfg_valid,
    output logic [1:0]       cfg_addr,
    output logic [15:0]      cfg_data,
    input  logic             cfg_ready,
    output logic [OFF_W-1:0] h_off,
    output logic [OFF_W-1:0] v_off,
    output logic [1:0]       uart_fmt,
    output logic [1:0]       vga_fmt,
    output logic             busy,
    output logic             cfg_err
);

    localparam int TMO_W = $clog2(ACK_TMO + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [3:0]       lvl_s, lvl_q_r, press_s;
    logic [3:0]       pend_r, pend_s, clr_s;
    logic [1:0]       ptr_r, ptr_s, grant_s, search_idx_s;
    logic             found_s, err_set_s;
    logic [15:0]      new_val_s;
    logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_s;
    logic             cfg_valid_r, cfg_valid_s;
    logic [1:0]       cfg_addr_r, cfg_addr_s;
    logic [15:0]      cfg_data_r, cfg_data_s;
    logic [OFF_W-1:0] h_off_r, h_off_s, v_off_r, v_off_s;
    logic [1:0]       uart_fmt_r, uart_fmt_s, vga_fmt_r, vga_fmt_s;
    logic             busy_r, busy_s, cfg_err_r, cfg_err_s;

    // Step a setting by a fixed amount; any result beyond the legal maximum wraps to zero.
    function automatic logic [15:0] wrap_inc(input logic [15:0] cur,
                                             input logic [15:0] step,
                                             input logic [15:0] lim);
        logic [16:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        if (sum > {1'b0, lim}) begin
            wrap_inc = 16'd0;
        end else begin
            wrap_inc = sum[15:0];
        end
    endfunction

    assign lvl_s   = {DF_VGA, DF_UART, VS, HS};
    assign press_s = lvl_s & ~lvl_q_r;

    // Round-robin search for the first pending event at or above the pointer.
    always_comb begin
        found_s      = 1'b0;
        grant_s      = ptr_r;
        search_idx_s = ptr_r;
        for (int k = 0; k < 4; k++) begin
            search_idx_s = ptr_r + 2'(k);
            if (!found_s && pend_r[search_idx_s]) begin
                found_s = 1'b1;
                grant_s = search_idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Candidate value for the granted setting, derived from its committed value.
    always_comb begin
        case (grant_s)
            2'd0:    new_val_s = wrap_inc(16'(h_off_r), 16'(HS_STEP), 16'(H_MAX));
            2'd1:    new_val_s = wrap_inc(16'(v_off_r), 16'(VS_STEP), 16'(V_MAX));
            2'd2:    new_val_s = wrap_inc(16'(uart_fmt_r), 16'd1, 16'(UART_FMT_N - 1));
            2'd3:    new_val_s = wrap_inc(16'(vga_fmt_r), 16'd1, 16'(VGA_FMT_N - 1));
            default: new_val_s = 16'd0;
        endcase
    end

    // Next-state, write-port and commit logic.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        clr_s       = 4'd0;
        err_set_s   = 1'b0;
        tmo_cnt_s   = tmo_cnt_r;
        cfg_valid_s = cfg_valid_r;
        cfg_addr_s  = cfg_addr_r;
        cfg_data_s  = cfg_data_r;
        h_off_s     = h_off_r;
        v_off_s     = v_off_r;
        uart_fmt_s  = uart_fmt_r;
        vga_fmt_s   = vga_fmt_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_s     = ST_SEND;
                    cfg_valid_s = 1'b1;
                    cfg_addr_s  = grant_s;
                    cfg_data_s  = new_val_s;
                    ptr_s       = grant_s + 2'd1;
                    tmo_cnt_s   = TMO_W'(0);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (cfg_valid_r && cfg_ready) begin
                    case (cfg_addr_r)
                        2'd0:    h_off_s    = cfg_data_r[OFF_W-1:0];
                        2'd1:    v_off_s    = cfg_data_r[OFF_W-1:0];
                        2'd2:    uart_fmt_s = cfg_data_r[1:0];
                        2'd3:    vga_fmt_s  = cfg_data_r[1:0];
                        default: h_off_s    = h_off_r;
                    endcase
                    clr_s[cfg_addr_r] = 1'b1;
                    cfg_valid_s       = 1'b0;
                    tmo_cnt_s         = TMO_W'(0);
                    state_s           = ST_IDLE;
                end else if (tmo_cnt_r == TMO_W'(ACK_TMO - 1)) begin
                    clr_s[cfg_addr_r] = 1'b1;
                    err_set_s         = 1'b1;
                    cfg_valid_s       = 1'b0;
                    tmo_cnt_s         = TMO_W'(0);
                    state_s           = ST_IDLE;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
                end
            end
            default: begin
                state_s     = ST_IDLE;
                cfg_valid_s = 1'b0;
            end
        endcase
    end

    // A new press outranks a same-edge clear so no event is ever lost.
    always_comb begin
        pend_s    = (pend_r & ~clr_s) | press_s;
        cfg_err_s = err_set_s | (cfg_err_r & ~err_clr);
        busy_s    = (state_s == ST_SEND) || (pend_s != 4'd0);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            lvl_q_r     <= 4'd0;
            pend_r      <= 4'd0;
            ptr_r       <= 2'd0;
            tmo_cnt_r   <= TMO_W'(0);
            cfg_valid_r <= 1'b0;
            cfg_addr_r  <= 2'd0;
            cfg_data_r  <= 16'd0;
            h_off_r     <= {OFF_W{1'b0}};
            v_off_r     <= {OFF_W{1'b0}};
            uart_fmt_r  <= 2'd0;
            vga_fmt_r   <= 2'd0;
            busy_r      <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            lvl_q_r     <= lvl_s;
            pend_r      <= pend_s;
            ptr_r       <= ptr_s;
            tmo_cnt_r   <= tmo_cnt_s;
            cfg_valid_r <= cfg_valid_s;
            cfg_addr_r  <= cfg_addr_s;
            cfg_data_r  <= cfg_data_s;
            h_off_r     <= h_off_s;
            v_off_r     <= v_off_s;
            uart_fmt_r  <= uart_fmt_s;
            vga_fmt_r   <= vga_fmt_s;
            busy_r      <= busy_s;
            cfg_err_r   <= cfg_err_s;
        end
    end

    assign cfg_valid = cfg_valid_r;
    assign cfg_addr  = cfg_addr_r;
    assign cfg_data  = cfg_data_r;
    assign h_off     = h_off_r;
    assign v_off     = v_off_r;
    assign uart_fmt  = uart_fmt_r;
    assign vga_fmt   = vga_fmt_r;
    assign busy      = busy_r;
    assign cfg_err   = cfg_err_r;

endmodule
